// File: rtl/mem_bank.sv
// Byte-addressed single-port SRAM bank with strobed byte-lane writes and a registered read port.
// Any lane may start at any byte; lane addresses wrap at the top of the array.
module mem_bank #(
    parameter  int AddrWidth = 8,
    parameter  int DataSize  = 2,
    localparam int DataBytes = 2 ** DataSize,
    localparam int DataWidth = 8 * DataBytes,
    localparam int Depth     = 2 ** AddrWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cs_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [DataBytes-1:0] wstrb_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [7:0]           mem_q [Depth];
    logic [AddrWidth-1:0] lane_addr [DataBytes];
    logic [DataWidth-1:0] rdata_d;
    logic [DataWidth-1:0] rdata_q;

    // Truncation to AddrWidth bits gives the modulo wrap for free.
    for (genvar g = 0; g < DataBytes; g++) begin : g_lane_addr
        assign lane_addr[g] = addr_i + AddrWidth'(g);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cs_i) begin
            for (int i = 0; i < DataBytes; i++) begin
                rdata_d[8*i +: 8] = mem_q[lane_addr[i]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Array is not reset; reset only suppresses the write. Non-blocking update
    // means a same-edge read sees the old contents.
    always_ff @(posedge clk_i) begin
        if (rst_ni && cs_i) begin
            for (int i = 0; i < DataBytes; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[lane_addr[i]] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_bank.sv
// Directed bench for mem_bank (AddrWidth=8, DataSize=2) with hand-computed expectations.
module tb_mem_bank;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    mem_bank #(.AddrWidth(8), .DataSize(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cs_i   (cs),
        .addr_i (addr),
        .wdata_i(wdata),
        .wstrb_i(wstrb),
        .rdata_o(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic c, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        cs    = c;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cs    = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        @(negedge clk);
        step(1'b0, 8'h00, 32'h0, 4'h0);
        step(1'b0, 8'h00, 32'h0, 4'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        // Test 1: full write then read back
        step(1'b1, 8'h10, 32'hDEADBEEF, 4'b1111);
        step(1'b1, 8'h10, 32'hDEADBEEF, 4'b1111);
        check("t1_full_rw", rdata, 32'hDEADBEEF);
        step(1'b1, 8'h10, 32'hFFFFFFFF, 4'b0000);
        check("t1_readback", rdata, 32'hDEADBEEF);

        // Test 4: zero strobe, unaligned read (mem[0x14] set to 0x77 first)
        step(1'b1, 8'h14, 32'hFFFFFF77, 4'b0001);
        step(1'b1, 8'h11, 32'h00000000, 4'b0000);
        check("t4_unaligned", rdata, 32'h77DEADBE);
        step(1'b1, 8'h10, 32'h00000000, 4'b0000);
        check("t4_no_write", rdata, 32'hDEADBEEF);

        // Test 2: partial strobe, also read-before-write on the strobed edge
        step(1'b1, 8'h20, 32'h11223344, 4'b1111);
        step(1'b1, 8'h20, 32'hAABBCCDD, 4'b1010);
        check("t2_rbw_old", rdata, 32'h11223344);
        step(1'b1, 8'h20, 32'h0, 4'b0000);
        check("t2_partial", rdata, 32'hAA22CC44);

        // Test 3: chip select low holds rdata and blocks writes
        step(1'b1, 8'h10, 32'h0, 4'b0000);
        step(1'b0, 8'h20, 32'h0, 4'b1111);
        check("t3_hold1", rdata, 32'hDEADBEEF);
        step(1'b0, 8'h20, 32'h0, 4'b1111);
        check("t3_hold2", rdata, 32'hDEADBEEF);
        step(1'b1, 8'h20, 32'h0, 4'b0000);
        check("t3_no_write", rdata, 32'hAA22CC44);

        // Test 5: wrap-around
        step(1'b1, 8'hFE, 32'h01020304, 4'b1111);
        step(1'b1, 8'hFE, 32'h0, 4'b0000);
        check("t5_wrap_read", rdata, 32'h01020304);
        step(1'b1, 8'h00, 32'h0, 4'b0000);
        check("t5_low_bytes", {16'h0, rdata[15:0]}, 32'h00000102);

        // Unaligned write spanning an aligned word boundary
        step(1'b1, 8'h40, 32'h00000000, 4'b1111);
        step(1'b1, 8'h41, 32'hA1B2C3D4, 4'b1111);
        step(1'b1, 8'h40, 32'h0, 4'b0000);
        check("unal_write_lo", rdata, 32'hB2C3D400);
        step(1'b1, 8'h44, 32'h0, 4'b0000);
        check("unal_write_hi", {24'h0, rdata[7:0]}, 32'h000000A1);

        // Test 6: reset mid-operation suppresses the write and clears rdata
        step(1'b1, 8'h30, 32'h12345678, 4'b1111);
        step(1'b1, 8'h10, 32'h0, 4'b0000);
        check("t6_pre", rdata, 32'hDEADBEEF);
        rst_n = 1'b0;
        step(1'b1, 8'h30, 32'h55555555, 4'b1111);
        check("t6_reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 8'h30, 32'h0, 4'b0000);
        check("t6_suppressed", rdata, 32'h12345678);
        step(1'b1, 8'h10, 32'h0, 4'b0000);
        check("t6_retained", rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
